// File: rtl/up_down_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : up_down_sweep_ctrl (with helper up_down_counter)
//  Purpose  : Command-driven sweep sequencer around an up/down counter.
//             Runs a single up ramp, a single down ramp, or a repeated
//             lo<->hi ping-pong, and holds the count whenever idle.
//  Ports    : clk, rst_n          - clock / async active-low reset
//             cmd_valid/cmd_ready - command handshake
//             cmd_mode            - 00 UP, 01 DOWN, 10 PINGPONG, 11 reserved
//             cmd_lo/cmd_hi       - unsigned sweep bounds
//             cmd_reps            - ping-pong round trips (0 treated as 1)
//             abort               - stop the current sweep
//             count               - counter value
//             busy/done/err       - status (done/err are one-cycle pulses)
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  up_down_counter: loadable up/down counter with no enable. Holding is done
//  by loading the current value back.
// ----------------------------------------------------------------------------
module up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             up_down,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= data_in;
    end else if (up_down) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

module up_down_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int REPW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic [REPW-1:0]  cmd_reps,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] lo_r, hi_r;
  logic [REPW-1:0]  reps_r;

  logic             load, up_down;
  logic [WIDTH-1:0] data_in;
  logic             accept, set_done, set_err, reps_dec;

  up_down_counter #(.WIDTH(WIDTH)) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .up_down (up_down),
    .data_in (data_in),
    .count   (count)
  );

  assign cmd_ready = (state == IDLE) & ~abort;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid & cmd_ready;

  // Next-state and counter control. Default is "hold": reload current count.
  always_comb begin
    next_state = state;
    load       = 1'b1;
    up_down    = 1'b1;
    data_in    = count;
    set_done   = 1'b0;
    set_err    = 1'b0;
    reps_dec   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_mode == MODE_RSVD || cmd_lo > cmd_hi) begin
            set_err = 1'b1;
          end else if (cmd_mode == MODE_DOWN) begin
            data_in    = cmd_hi;
            next_state = RUN_DOWN;
          end else begin
            data_in    = cmd_lo;
            next_state = RUN_UP;
          end
        end
      end

      RUN_UP: begin
        if (abort) begin
          next_state = IDLE;
        end else if (count != hi_r) begin
          load    = 1'b0;
          up_down = 1'b1;
        end else if (mode_r == MODE_PP && lo_r != hi_r) begin
          // Turn around at the top without a dead cycle.
          load       = 1'b0;
          up_down    = 1'b0;
          next_state = RUN_DOWN;
        end else begin
          // UP complete, or a degenerate lo==hi ping-pong.
          set_done   = 1'b1;
          next_state = IDLE;
        end
      end

      RUN_DOWN: begin
        if (abort) begin
          next_state = IDLE;
        end else if (count != lo_r) begin
          load    = 1'b0;
          up_down = 1'b0;
        end else if (mode_r == MODE_PP && reps_r > REPW'(1)) begin
          reps_dec   = 1'b1;
          load       = 1'b0;
          up_down    = 1'b1;
          next_state = RUN_UP;
        end else begin
          reps_dec   = (mode_r == MODE_PP);
          set_done   = 1'b1;
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_r <= MODE_UP;
      lo_r   <= '0;
      hi_r   <= '0;
      reps_r <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= next_state;
      done  <= set_done;
      err   <= set_err;
      if (accept) begin
        mode_r <= cmd_mode;
        lo_r   <= cmd_lo;
        hi_r   <= cmd_hi;
        reps_r <= (cmd_reps == '0) ? REPW'(1) : cmd_reps;
      end else if (reps_dec) begin
        reps_r <= reps_r - REPW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_up_down_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_up_down_sweep_ctrl
//  Purpose  : Directed self-checking bench for up_down_sweep_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_up_down_sweep_ctrl;

  localparam int WIDTH = 4;
  localparam int REPW  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [WIDTH-1:0] cmd_lo, cmd_hi;
  logic [REPW-1:0]  cmd_reps;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy, done, err;

  int checks = 0;
  int errors = 0;

  up_down_sweep_ctrl #(.WIDTH(WIDTH), .REPW(REPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_lo    (cmd_lo),
    .cmd_hi    (cmd_hi),
    .cmd_reps  (cmd_reps),
    .abort     (abort),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; leave time at edge+1 so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge (E0); returns just after E0.
  task automatic send(input logic [1:0] m, input int lo, input int hi, input int reps);
    cmd_mode  = m;
    cmd_lo    = WIDTH'(lo);
    cmd_hi    = WIDTH'(hi);
    cmd_reps  = REPW'(reps);
    cmd_valid = 1'b1;
    #1;
    chk("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  int pp2 [9] = '{3, 4, 5, 4, 3, 4, 5, 4, 3};
  int pp1 [5] = '{3, 4, 5, 4, 3};

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00;
    cmd_lo = '0; cmd_hi = '0; cmd_reps = '0; abort = 1'b0;
    step(); step();

    // ---- reset state ----
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_err",   {31'd0, err},   32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    abort = 1'b1; #1;
    chk("rst_ready_abort", {31'd0, cmd_ready}, 32'd0);
    abort = 1'b0;
    rst_n = 1'b1;

    // ---- UP 2..5 ----
    send(2'b00, 2, 5, 0);
    chk("up_e0_count", {28'd0, count}, 32'd2);
    chk("up_e0_busy",  {31'd0, busy},  32'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("up_count", {28'd0, count}, 32'(2 + k));
      chk("up_nodone", {31'd0, done}, 32'd0);
    end
    step();
    chk("up_done",  {31'd0, done}, 32'd1);
    chk("up_busy0", {31'd0, busy}, 32'd0);
    chk("up_hold5", {28'd0, count}, 32'd5);
    chk("up_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    chk("up_done_pulse", {31'd0, done}, 32'd0);
    for (int k = 0; k < 10; k++) step();
    chk("up_idle_hold", {28'd0, count}, 32'd5);

    // ---- DOWN 0..15, no wrap ----
    send(2'b01, 0, 15, 0);
    chk("dn_e0_count", {28'd0, count}, 32'd15);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("dn_count", {28'd0, count}, 32'(15 - k));
    end
    chk("dn_busy_at_lo", {31'd0, busy}, 32'd1);
    step();
    chk("dn_done",  {31'd0, done}, 32'd1);
    chk("dn_hold0", {28'd0, count}, 32'd0);
    step();
    chk("dn_nowrap", {28'd0, count}, 32'd0);

    // ---- UP 14..15, no wrap ----
    send(2'b00, 14, 15, 0);
    chk("up2_e0", {28'd0, count}, 32'd14);
    step();
    chk("up2_e1", {28'd0, count}, 32'd15);
    step();
    chk("up2_done", {31'd0, done}, 32'd1);
    step();
    chk("up2_nowrap", {28'd0, count}, 32'd15);

    // ---- PINGPONG 3..5 reps=2 ----
    send(2'b10, 3, 5, 2);
    chk("pp2_e0", {28'd0, count}, 32'(pp2[0]));
    for (int k = 1; k < 9; k++) begin
      step();
      chk("pp2_count", {28'd0, count}, 32'(pp2[k]));
      chk("pp2_busy",  {31'd0, busy},  32'd1);
      chk("pp2_nodone", {31'd0, done}, 32'd0);
    end
    step();
    chk("pp2_done",  {31'd0, done},  32'd1);
    chk("pp2_end",   {28'd0, count}, 32'd3);
    chk("pp2_busy0", {31'd0, busy},  32'd0);

    // ---- PINGPONG reps=0 behaves as reps=1 ----
    send(2'b10, 3, 5, 0);
    for (int k = 1; k < 5; k++) begin
      step();
      chk("pp1_count", {28'd0, count}, 32'(pp1[k]));
    end
    step();
    chk("pp1_done", {31'd0, done}, 32'd1);

    // ---- rejects ----
    send(2'b11, 1, 4, 0);
    chk("rej1_err",   {31'd0, err},  32'd1);
    chk("rej1_busy",  {31'd0, busy}, 32'd0);
    chk("rej1_count", {28'd0, count}, 32'd3);
    chk("rej1_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    chk("rej1_err_pulse", {31'd0, err}, 32'd0);
    send(2'b00, 6, 2, 0);
    chk("rej2_err",   {31'd0, err},  32'd1);
    chk("rej2_busy",  {31'd0, busy}, 32'd0);
    chk("rej2_count", {28'd0, count}, 32'd3);
    step();
    chk("rej2_err_pulse", {31'd0, err}, 32'd0);
    chk("rej2_nodone", {31'd0, done}, 32'd0);

    // ---- abort UP 0..12 at count 7 ----
    send(2'b00, 0, 12, 0);
    for (int k = 1; k <= 7; k++) step();
    chk("ab_count7", {28'd0, count}, 32'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_hold",   {28'd0, count}, 32'd7);
    chk("ab_busy0",  {31'd0, busy},  32'd0);
    chk("ab_nodone", {31'd0, done},  32'd0);
    send(2'b00, 7, 8, 0);
    chk("ab_next_e0", {28'd0, count}, 32'd7);
    chk("ab_next_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    chk("ab_next_done", {31'd0, done}, 32'd1);
    chk("ab_next_end", {28'd0, count}, 32'd8);

    // ---- async reset mid-PINGPONG ----
    send(2'b10, 0, 9, 3);
    for (int k = 1; k <= 5; k++) step();
    chk("rst_mid_count", {28'd0, count}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", {28'd0, count}, 32'd0);
    chk("arst_busy",  {31'd0, busy},  32'd0);
    step();
    rst_n = 1'b1;
    send(2'b00, 1, 3, 0);
    chk("post_e0", {28'd0, count}, 32'd1);
    step();
    chk("post_e1", {28'd0, count}, 32'd2);
    step();
    chk("post_e2", {28'd0, count}, 32'd3);
    step();
    chk("post_done", {31'd0, done}, 32'd1);
    chk("post_busy0", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
